// File: rtl/seg7_capture_encoder.sv
// Deglitches an active-low 7-segment bus and recovers the BCD digit it shows.
// Optional saturating illegal-pattern counter is built only when SEG7_ERR_COUNT_EN is defined.
module seg7_capture_encoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic [3:0] digit,
  output logic       blank,
  output logic       err,
  output logic       valid,
  output logic       stable,
  output logic [7:0] err_count
);

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  state_t     state;
  state_t     state_nxt;
  logic [6:0] samp;
  logic [6:0] commit;
  logic [7:0] cnt;

  logic       same;
  logic       accept;
  logic       changed;
  logic [3:0] enc_digit;
  logic       enc_blank;
  logic       enc_err;

  // Acceptance fires once per settle, on the edge that brings cnt to STABLE_CYCLES.
  always_comb begin
    same      = (seg_in == samp);
    accept    = same && (state == SETTLE) && (cnt == STABLE_MAX - 8'd1);
    changed   = accept && (samp != commit);
    state_nxt = state;
    if (!same) begin
      state_nxt = SETTLE;
    end else if (accept) begin
      state_nxt = LOCKED;
    end
  end

  always_comb begin
    enc_digit = 4'hF;
    enc_blank = 1'b0;
    enc_err   = 1'b0;
    case (samp)
      7'b0000001: enc_digit = 4'd0;
      7'b1001111: enc_digit = 4'd1;
      7'b0010010: enc_digit = 4'd2;
      7'b0000110: enc_digit = 4'd3;
      7'b1001100: enc_digit = 4'd4;
      7'b0100100: enc_digit = 4'd5;
      7'b0100000: enc_digit = 4'd6;
      7'b0001111: enc_digit = 4'd7;
      7'b0000000: enc_digit = 4'd8;
      7'b0000100: enc_digit = 4'd9;
      SEG_BLANK: begin
        enc_digit = 4'd0;
        enc_blank = 1'b1;
      end
      default: enc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SETTLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp   <= SEG_BLANK;
      commit <= SEG_BLANK;
      cnt    <= 8'd0;
      digit  <= 4'd0;
      blank  <= 1'b1;
      err    <= 1'b0;
      valid  <= 1'b0;
    end else begin
      samp  <= seg_in;
      valid <= changed;
      if (!same) begin
        cnt <= 8'd0;
      end else if (cnt < STABLE_MAX) begin
        cnt <= cnt + 8'd1;
      end
      // A glitch that settles back onto the committed pattern updates nothing.
      if (changed) begin
        commit <= samp;
        digit  <= enc_digit;
        blank  <= enc_blank;
        err    <= enc_err;
      end
    end
  end

  assign stable = (state == LOCKED);

`ifdef SEG7_ERR_COUNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (changed && enc_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign err_count = err_cnt;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_seg7_capture_encoder.sv
// Bench for seg7_capture_encoder: vector table, hand-written corner sequences and
// randomized traffic checked every cycle against a run-length reference model.
module tb_seg7_capture_encoder;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in = 7'b1111111;
  logic [3:0] digit;
  logic       blank;
  logic       err;
  logic       valid;
  logic       stable;
  logic [7:0] err_count;

  int checks = 0;
  int passed = 0;
  int vcount = 0;

  seg7_capture_encoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .digit(digit), .blank(blank),
    .err(err), .valid(valid), .stable(stable), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference model: run length of the current input value, last accepted pattern.
  logic [6:0] m_val = 7'b1111111;
  int         m_len = 1;
  logic [6:0] m_commit = 7'b1111111;
  logic [3:0] m_digit = 4'd0;
  logic       m_blank = 1'b1;
  logic       m_err = 1'b0;
  logic       m_valid = 1'b0;
  logic       m_stable = 1'b0;
  int         m_errcnt = 0;

  function automatic logic [6:0] pat_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  // Returns {digit, blank, err} for a pattern.
  function automatic logic [5:0] classify(input logic [6:0] p);
    if (p == 7'b1111111) return {4'd0, 1'b1, 1'b0};
    for (int d = 0; d < 10; d++)
      if (pat_of(d) == p) return {4'(d), 1'b0, 1'b0};
    return {4'hF, 1'b0, 1'b1};
  endfunction

  task automatic model_step(input logic [6:0] x, input logic r);
    logic [5:0] c;
    m_valid = 1'b0;
    if (r) begin
      m_val = 7'b1111111; m_len = 1; m_commit = 7'b1111111;
      m_digit = 4'd0; m_blank = 1'b1; m_err = 1'b0; m_errcnt = 0;
      m_stable = 1'b0;
    end else begin
      if (x != m_val) begin
        m_val = x;
        m_len = 1;
      end else if (m_len <= S) begin
        m_len++;
        if (m_len == S + 1 && m_val != m_commit) begin
          m_commit = m_val;
          c = classify(m_val);
          {m_digit, m_blank, m_err} = c;
          m_valid = 1'b1;
`ifdef SEG7_ERR_COUNT_EN
          if (m_err && m_errcnt < 255) m_errcnt++;
`endif
        end
      end
      m_stable = (m_len == S + 1);
    end
  endtask

  task automatic check_cycle(input string tag);
    logic [15:0] got, exp;
    got = {digit, blank, err, valid, stable, err_count};
    exp = {m_digit, m_blank, m_err, m_valid, m_stable, 8'(m_errcnt)};
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got digit=%h blank=%b err=%b valid=%b stable=%b err_count=%0d, expected digit=%h blank=%b err=%b valid=%b stable=%b err_count=%0d",
                  tag, digit, blank, err, valid, stable, err_count,
                  m_digit, m_blank, m_err, m_valid, m_stable, m_errcnt);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic cyc(input logic [6:0] x, input logic r, input string tag);
    seg_in = x;
    rst = r;
    @(posedge clk);
    model_step(x, r);
    #1;
    if (valid === 1'b1) vcount++;
    check_cycle(tag);
  endtask

  typedef struct {
    logic [6:0] seg;
    logic [3:0] digit;
    logic       blank;
    logic       err;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int pulse_at;
    int exp_errs;

    tbl[0]  = '{7'b1010101, 4'hF, 1'b0, 1'b1};
    tbl[1]  = '{7'b0000001, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{7'b0110110, 4'hF, 1'b0, 1'b1};
    tbl[3]  = '{7'b0000001, 4'd0, 1'b0, 1'b0};
    tbl[4]  = '{7'b1001111, 4'd1, 1'b0, 1'b0};
    tbl[5]  = '{7'b0010010, 4'd2, 1'b0, 1'b0};
    tbl[6]  = '{7'b0000110, 4'd3, 1'b0, 1'b0};
    tbl[7]  = '{7'b1001100, 4'd4, 1'b0, 1'b0};
    tbl[8]  = '{7'b0100100, 4'd5, 1'b0, 1'b0};
    tbl[9]  = '{7'b0100000, 4'd6, 1'b0, 1'b0};
    tbl[10] = '{7'b0001111, 4'd7, 1'b0, 1'b0};
    tbl[11] = '{7'b0000000, 4'd8, 1'b0, 1'b0};
    tbl[12] = '{7'b0000100, 4'd9, 1'b0, 1'b0};
    tbl[13] = '{7'b1111111, 4'd0, 1'b1, 1'b0};
    tbl[14] = '{7'b1111110, 4'hF, 1'b0, 1'b1};

    // Reset state
    cyc(7'b1111111, 1'b1, "reset");
    cyc(7'b1111111, 1'b1, "reset");
    chk("reset_digit", int'(digit), 0);
    chk("reset_blank", int'(blank), 1);
    chk("reset_stable", int'(stable), 0);

    // Hold 2: single pulse on E4, none afterwards
    vcount = 0;
    pulse_at = -1;
    for (int i = 0; i < 10; i++) begin
      cyc(7'b0010010, 1'b0, "hold2");
      if (valid === 1'b1 && pulse_at < 0) pulse_at = i;
    end
    chk("hold2_pulse_edge", pulse_at, S);
    chk("hold2_pulses", vcount, 1);
    chk("hold2_digit", int'(digit), 2);
    chk("hold2_stable", int'(stable), 1);

    // Glitch to 8 for two cycles, settles back on 2
    vcount = 0;
    cyc(7'b0000000, 1'b0, "glitch");
    chk("glitch_stable_drop", int'(stable), 0);
    cyc(7'b0000000, 1'b0, "glitch");
    for (int i = 0; i < S; i++) cyc(7'b0010010, 1'b0, "glitch_return");
    chk("glitch_not_yet_stable", int'(stable), 0);
    cyc(7'b0010010, 1'b0, "glitch_return");
    chk("glitch_stable_back", int'(stable), 1);
    chk("glitch_no_valid", vcount, 0);
    chk("glitch_digit", int'(digit), 2);

    // Vector table: each entry held 6 cycles, one pulse per entry
    vcount = 0;
    exp_errs = 0;
    for (int v = 0; v < 15; v++) begin
      for (int i = 0; i < 6; i++) cyc(tbl[v].seg, 1'b0, "table");
      chk("table_digit", int'(digit), int'(tbl[v].digit));
      chk("table_blank", int'(blank), int'(tbl[v].blank));
      chk("table_err", int'(err), int'(tbl[v].err));
      if (tbl[v].err) exp_errs++;
      if (v == 2) begin
`ifdef SEG7_ERR_COUNT_EN
        chk("table_err_count", int'(err_count), 2);
`else
        chk("table_err_count", int'(err_count), 0);
`endif
      end
    end
    chk("table_pulses", vcount, 15);

    // Lock on 7, then blank; then reset at E2 of a new settle
    for (int i = 0; i < 6; i++) cyc(7'b0001111, 1'b0, "lock7");
    chk("lock7_digit", int'(digit), 7);
    vcount = 0;
    for (int i = 0; i < 6; i++) cyc(7'b1111111, 1'b0, "to_blank");
    chk("to_blank_pulses", vcount, 1);
    chk("to_blank_blank", int'(blank), 1);
    chk("to_blank_digit", int'(digit), 0);
    vcount = 0;
    cyc(7'b0000110, 1'b0, "mid_settle");
    cyc(7'b0000110, 1'b0, "mid_settle");
    cyc(7'b0000110, 1'b1, "mid_settle_rst");
    chk("rst_mid_blank", int'(blank), 1);
    chk("rst_mid_err_count", int'(err_count), 0);
    for (int i = 0; i < 3; i++) cyc(7'b0000110, 1'b0, "after_rst");
    chk("after_rst_no_valid", vcount, 0);
    for (int i = 0; i < 4; i++) cyc(7'b0000110, 1'b0, "after_rst");
    chk("after_rst_digit", int'(digit), 3);

    // Randomized traffic against the model
    for (int s = 0; s < 300; s++) begin
      logic [6:0] p;
      int hold;
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 50) p = pat_of($urandom_range(0, 9));
      else if (sel < 65) p = 7'b1111111;
      else p = 7'($urandom);
      hold = $urandom_range(1, 7);
      for (int i = 0; i < hold; i++)
        cyc(p, ($urandom_range(0, 39) == 0), "random");
    end

    // Error counter saturation: 260 illegal acceptances
    cyc(7'b1111111, 1'b1, "sat_reset");
    for (int k = 0; k < 260; k++) begin
      for (int i = 0; i < 6; i++) cyc(7'b1010101, 1'b0, "sat_illegal");
      for (int i = 0; i < 6; i++) cyc(7'b0000000, 1'b0, "sat_legal");
    end
`ifdef SEG7_ERR_COUNT_EN
    chk("err_count_saturated", int'(err_count), 255);
`else
    chk("err_count_tied", int'(err_count), 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
